// File: rtl/lc3_reg_tracer.sv
// lc3_reg_tracer: LC-3 register-file write tracer with timestamped show-ahead FIFO; LC3_TRACE_PC_EN adds PC capture
module lc3_reg_tracer #(
  parameter int DATA_W     = 16,
  parameter int NREGS      = 8,
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 16,
  parameter int TS_W       = 16,
  parameter int MAX_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LC3_TRACE_PC_EN
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] out_pc,
`endif
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TS_W-1:0]   out_ts,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic [TS_W-1:0]   cycle_cnt,
  output logic              done
);
  localparam int PW = $clog2(DEPTH);
`ifdef LC3_TRACE_PC_EN
  localparam int EW = 2*DATA_W + TS_W + ADDR_W;
`else
  localparam int EW = DATA_W + TS_W + ADDR_W;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [TS_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q [NREGS];
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head_q, head_d, entry;
  logic [PW:0] wptr_q, rptr_q, rptr_d, count_d;
  logic [7:0] drop_q;
  logic ovf_q, in_range, capture, full, pop, push, drop;
  if (NREGS >= (1 << ADDR_W)) begin : g_all
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = 32'(wr_addr) < NREGS;
  end
`ifdef LC3_TRACE_PC_EN
  assign entry  = {pc, cnt_q, wr_addr, wr_data};
  assign out_pc = head_q[EW-1 -: DATA_W];
`else
  assign entry = {cnt_q, wr_addr, wr_data};
`endif
  assign capture   = state_q == RUN && wr_en && in_range && wr_data != shadow_q[wr_addr];
  assign out_valid = wptr_q != rptr_q;
  assign full      = (wptr_q - rptr_q) == (PW+1)'(DEPTH);
  assign pop       = out_valid && out_ready;
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign rptr_d    = rptr_q + (PW+1)'(pop);
  assign count_d   = wptr_q + (PW+1)'(push) - rptr_d;
  assign head_d    = count_d == '0 ? head_q :
                     (push && count_d == (PW+1)'(1)) ? entry : mem_q[rptr_d[PW-1:0]];
  assign out_ts    = head_q[DATA_W+ADDR_W +: TS_W];
  assign out_reg   = head_q[DATA_W +: ADDR_W];
  assign out_data  = head_q[DATA_W-1:0];
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
  assign cycle_cnt = cnt_q;
  assign done      = state_q == DONE;
  // Run control: rearm on en low, count cycles in RUN, stop at the budget
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != IDLE && !en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE && en) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + TS_W'(1);
      if (MAX_CYCLES != 0 && cnt_q == TS_W'(MAX_CYCLES - 1)) state_d = DONE;
    end
  end
  // State, shadow copy, FIFO pointers, registered head and drop accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_en && in_range) shadow_q[wr_addr] <= wr_data;
      wptr_q  <= wptr_q + (PW+1)'(push);
      rptr_q  <= rptr_d;
      head_q  <= head_d;
      ovf_q   <= ovf_q || drop;
      drop_q  <= (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end
  end
  // Entry storage needs no reset; occupancy lives in the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PW-1:0]] <= entry;
  end
endmodule

// File: tb/tb_lc3_reg_tracer.sv
// tb_lc3_reg_tracer: randomized and directed checks against a queue-based trace model
module tb_lc3_reg_tracer;
  localparam int MAXC = 100;
  localparam int DEP  = 16;
  logic clk = 0, rst = 0, en = 0, wr_en = 0, out_ready = 0;
  logic [2:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic out_valid, overflow, done;
  logic [15:0] out_ts, out_data, cycle_cnt;
  logic [2:0] out_reg;
  logic [7:0] drop_cnt;
  typedef struct {int ts; int rg; int data;} ent_t;
  ent_t q[$];
  ent_t last;
  int shadow [8];
  int st, cnt, drops, checks, errors, prev_ts;
  bit ovf;

  lc3_reg_tracer dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_reg(out_reg),
    .out_data(out_data), .overflow(overflow), .drop_cnt(drop_cnt), .cycle_cnt(cycle_cnt),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = '{0, 0, 0};
    for (int i = 0; i < 8; i++) shadow[i] = 0;
    st = 0; cnt = 0; drops = 0; ovf = 0;
  endtask

  task automatic model_step();
    bit pop, cap;
    ent_t e;
    pop = q.size() > 0 && out_ready;
    cap = st == 1 && wr_en && int'(wr_data) != shadow[wr_addr];
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEP) begin
        e.ts = cnt; e.rg = int'(wr_addr); e.data = int'(wr_data);
        q.push_back(e);
      end else begin
        ovf = 1;
        if (drops < 255) drops++;
      end
    end
    if (q.size() > 0) last = q[0];
    if (wr_en) shadow[wr_addr] = int'(wr_data);
    case (st)
      0: if (en) st = 1;
      1: if (!en) begin st = 0; cnt = 0; end
         else if (cnt == MAXC - 1) begin st = 2; cnt = MAXC; end
         else cnt = (cnt + 1) % 65536;
      default: if (!en) begin st = 0; cnt = 0; end
    endcase
  endtask

  task automatic verify();
    ent_t h;
    h = q.size() > 0 ? q[0] : last;
    check("valid", out_valid, q.size() > 0);
    check("ts", out_ts, h.ts);
    check("reg", out_reg, h.rg);
    check("data", out_data, h.data);
    check("cycle_cnt", cycle_cnt, cnt);
    check("done", done, st == 2);
    check("overflow", overflow, ovf);
    check("drop_cnt", drop_cnt, drops);
  endtask

  task automatic cyc(input bit e, input bit w, input int a, input int d, input bit r);
    en = e; wr_en = w; wr_addr = a[2:0]; wr_data = d[15:0]; out_ready = r;
    model_step();
    @(posedge clk);
    #1;
    verify();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    verify();
    rst = 1;
    // first entry timing and unchanged-value suppression
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 3, 5, 0);
    check("tp1_valid", out_valid, 1);
    check("tp1_ts", out_ts, 2);
    check("tp1_data", out_data, 5);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    check("tp1_single", out_valid, 0);
    // budget exhaustion
    for (int i = 0; i < 200 && st != 2; i++) cyc(1, 0, 0, 0, 1);
    check("tp2_done", done, 1);
    check("tp2_cnt", cycle_cnt, 100);
    cyc(1, 1, 1, 7, 1);
    check("tp2_no_entry", out_valid, 0);
    cyc(0, 0, 0, 0, 1);
    check("tp2_clr_cnt", cycle_cnt, 0);
    check("tp2_clr_done", done, 0);
    // overflow with a stalled consumer, then full capture+pop, then ordered drain
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, i % 8, 16'h100 + i, 0);
    check("tp3_ovf", overflow, 1);
    check("tp3_drops", drop_cnt, 4);
    check("tp3_head_ts", out_ts, 0);
    cyc(1, 1, 5, 16'h3333, 1);
    check("tp3_fullpop_drops", drop_cnt, 4);
    check("tp3_fullpop_head", out_ts, 1);
    prev_ts = -1;
    for (int i = 0; i < 40 && out_valid; i++) begin
      check("tp3_order", int'(out_ts) > prev_ts, 1);
      prev_ts = int'(out_ts);
      cyc(1, 0, 0, 0, 1);
    end
    check("tp3_empty", out_valid, 0);
    // shadow tracks writes made while idle
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 2, 9, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 2, 9, 0);
    check("tp5_same", out_valid, 0);
    cyc(1, 1, 2, 10, 0);
    check("tp5_reg", out_reg, 2);
    check("tp5_data", out_data, 10);
    cyc(1, 0, 0, 0, 1);
    // randomized traffic with varying consumer pressure
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 9) < (((i / 250) % 2) == 1 ? 8 : 2));
    // asynchronous reset mid-run with entries queued
    for (int i = 0; i < 40 && q.size() > 0; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, i, 16'h8000 + i, 0);
    check("tp6_queued", out_valid, 1);
    #3 rst = 0;
    #1;
    model_reset();
    check("tp6_valid", out_valid, 0);
    check("tp6_cnt", cycle_cnt, 0);
    check("tp6_ovf", overflow, 0);
    check("tp6_drops", drop_cnt, 0);
    #1 rst = 1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 4, 1, 0);
    check("tp6_ts", out_ts, 0);
    check("tp6_reg", out_reg, 4);
    check("tp6_data", out_data, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lc3_reg_tracer.md
Name: lc3_reg_tracer

Overview:
- Synthesizable register-file activity tracer for the LC-3 datapath.
- Snoops the register-file write port and keeps a shadow copy of every register.
- Logs each value-changing write as a timestamped entry in an internal show-ahead FIFO, drained over a valid/ready interface.
- A programmable cycle budget bounds each trace run.
- Replaces ad-hoc per-cycle register dumps in simulation and works unchanged on silicon/FPGA.

Parameters:
DATA_W, 16, register width
NREGS, 8, number of architectural registers
ADDR_W, 3, register index width (2^ADDR_W >= NREGS)
DEPTH, 16, trace FIFO entries (power of two, >= 2)
TS_W, 16, timestamp / cycle counter width
MAX_CYCLES, 100, cycles per run before done; 0 = unlimited

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  start/hold tracing; deassert to rearm
wr_en  in  1  register-file write strobe
wr_addr  in  ADDR_W  register-file write index
wr_data  in  DATA_W  register-file write data
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pop; pop occurs when out_valid & out_ready
out_ts  out  TS_W  head entry cycle stamp
out_reg  out  ADDR_W  head entry register index
out_data  out  DATA_W  head entry new value
overflow  out  1  sticky: at least one entry dropped
drop_cnt  out  8  dropped entries, saturates at 255
cycle_cnt  out  TS_W  cycles elapsed in current run
done  out  1  run budget exhausted

Behaviour:
- Reset (rst=0, asynchronous):
  - shadow registers = 0, FIFO empty, state IDLE.
  - out_valid=0; out_ts/out_reg/out_data=0.
  - overflow=0, drop_cnt=0, cycle_cnt=0, done=0.
- States:
  - IDLE -> RUN when en=1. cycle_cnt is 0 on the first RUN cycle.
  - RUN: cycle_cnt += 1 every clock, wrapping modulo 2^TS_W.
  - RUN -> DONE on the edge where cycle_cnt == MAX_CYCLES-1 (MAX_CYCLES != 0); cycle_cnt then holds MAX_CYCLES and done=1.
  - RUN or DONE -> IDLE when en=0: cycle_cnt cleared, done cleared.
  - Shadow, FIFO, overflow and drop_cnt persist across runs; only rst clears them.
- Shadow update:
  - Every wr_en with wr_addr < NREGS updates shadow[wr_addr], in any state.
  - wr_addr >= NREGS is ignored entirely: no shadow update, no capture.
- Capture:
  - Condition: state RUN, wr_en=1, wr_addr < NREGS, wr_data != shadow[wr_addr] (pre-update value).
  - Entry = {cycle_cnt current value, wr_addr, wr_data}.
  - Same-value writes are not logged.
  - Latency: entry appears at the FIFO head, with out_valid=1, one cycle after the write if the FIFO was empty.
- FIFO:
  - Show-ahead: out_* reflect the head whenever out_valid=1.
  - out_* hold their last value when empty; consumers must qualify with out_valid.
  - Order is strictly preserved.
- Full:
  - Capture with the FIFO full and no pop that cycle: the entry is dropped, overflow set, drop_cnt += 1 (saturating at 255).
  - Full with a simultaneous pop and capture: both succeed; occupancy unchanged; no drop.
- Empty with capture and out_ready=1 in the same cycle: no pop (out_valid was 0); the entry is pushed.
- Reset mid-run or mid-drain: immediate clear to reset values; in-flight entries are lost.
- MAX_CYCLES=0: never enters DONE; cycle_cnt wraps freely.

Optional Feature:
LC3_TRACE_PC_EN
- Defined:
  - Adds input pc (DATA_W) and output out_pc (DATA_W).
  - Each entry also stores the pc value sampled in the capture cycle.
  - out_pc resets to 0 and follows the FIFO head like the other fields.
- Undefined: no pc/out_pc ports and no PC storage; all other behaviour identical.

Test Plan:
- Reset, en=1, writes R3=5 at cycle 2 and R0=0 at cycle 3 -> one entry {ts=2, reg=3, data=5}; the R0 write is dropped as unchanged from 0; out_valid rises at cycle 3.
- en=1, MAX_CYCLES=100, no writes -> done=1 and cycle_cnt=100 after 100 clocks; a write R1=7 at cycle 101 produces no entry; en=0 clears done and cycle_cnt.
- out_ready=0, 20 distinct writes with DEPTH=16 -> 16 entries retained (first 16 in order), overflow=1, drop_cnt=4; draining returns ts in ascending order.
- FIFO full, capture and pop in the same cycle -> occupancy stays 16, drop_cnt unchanged, popped head is the oldest entry.
- Write R2=9 while in IDLE, then en=1 and write R2=9 -> no entries; then write R2=10 -> entry {reg=2, data=10}.
- rst pulsed low mid-run with 5 entries queued -> out_valid=0, cycle_cnt=0, overflow=0 asynchronously; the next R4=1 write after rearm logs with ts=0-relative timing.
